// File: rtl/pll_lock_if.sv
// pll_lock_if: lock/reset handshake between the PLL lock supervisor and the PLL/CPU side
//   locked        PLL locked indication (asynchronous to refclk)
//   pll_rst       PLL reset request, active-high
//   cpu_rst       CPU-domain reset request, active-high
//   ready         high only while the supervisor is in RUN
//   fail          sticky: lock retries exhausted
//   lock_loss     one-cycle pulse when lock drops in RUN
//   relock_count  saturating count of lock losses in RUN
interface pll_lock_if #(parameter int RELOCK_W = 8);
  logic                locked;
  logic                pll_rst;
  logic                cpu_rst;
  logic                ready;
  logic                fail;
  logic                lock_loss;
  logic [RELOCK_W-1:0] relock_count;
  modport master (input locked, output pll_rst, cpu_rst, ready, fail, lock_loss, relock_count);
  modport slave (output locked, input pll_rst, cpu_rst, ready, fail, lock_loss, relock_count);
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL reset, debounces lock, releases CPU reset after stable lock
//   refclk  reference clock, always running
//   rst     asynchronous active-high reset
//   bus     pll_lock_if.master: locked in; pll_rst, cpu_rst, ready, fail, lock_loss, relock_count out
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16,
  parameter int RELOCK_W            = 8
) (
  input logic       refclk,
  input logic       rst,
  pll_lock_if.master bus
);
  localparam int RET_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {S_PLL_RESET, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic [RET_W-1:0]       retry_q, retry_d;
  logic [RELOCK_W-1:0]    relock_q, relock_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic                   lock_loss_q, lock_loss_d;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // cnt_q times both PLL_RESET and STABLE; tmo_q is separate so that it
  // survives STABLE and a chattering lock still runs out the attempt.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.locked};
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    relock_d    = relock_q;
    lock_loss_d = 1'b0;
    case (state_q)
      S_PLL_RESET: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        tmo_d = tmo_q + CNT_W'(1);
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = retry_q + RET_W'(1);
          state_d = (retry_d == RET_MAX) ? S_FAIL : S_PLL_RESET;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = !locked_s ? S_WAIT_LOCK : (cnt_q == STB_LAST) ? S_RUN : S_STABLE;
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d     = S_PLL_RESET;
          cnt_d       = '0;
          retry_d     = '0;
          lock_loss_d = 1'b1;
          relock_d    = (&relock_q) ? relock_q : relock_q + RELOCK_W'(1);
        end
      end
      S_FAIL: state_d = S_FAIL;
      default: state_d = S_PLL_RESET;
    endcase
    pll_rst_d = state_d == S_PLL_RESET;
    cpu_rst_d = state_d != S_RUN;
    ready_d   = state_d == S_RUN;
    fail_d    = state_d == S_FAIL;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RESET;
      sync_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      cpu_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      cpu_rst_q   <= cpu_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_loss_q <= lock_loss_d;
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.cpu_rst      = cpu_rst_q;
  assign bus.ready        = ready_q;
  assign bus.fail         = fail_q;
  assign bus.lock_loss    = lock_loss_q;
  assign bus.relock_count = relock_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  pll_lock_if #(.RELOCK_W(2)) bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(16), .RELOCK_W(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );

  always #5 refclk = ~refclk;

  // outputs packed as {pll_rst, cpu_rst, ready, fail, lock_loss}
  logic [4:0] obs;
  assign obs = {bus.pll_rst, bus.cpu_rst, bus.ready, bus.fail, bus.lock_loss};

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.locked = 1'b0;
    tick();
    total++;
    if (obs !== 5'b11000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b11000);
    end
    total++;
    if (bus.relock_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_relock got=%0d exp=0", bus.relock_count);
    end
  endtask

  task automatic test_lock_sequence();
    logic [4:0] exp;
    do_reset();
    for (int n = 1; n <= 25; n++) begin
      tick();
      exp = {n < 4, n < 20, n >= 20, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL lock_seq tick=%0d got=%b exp=%b", n, obs, exp);
      end
      if (n == 9) bus.locked = 1'b1;
    end
  endtask

  task automatic test_stable_abort();
    logic [4:0] exp;
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      tick();
      exp = {n < 4 || n >= 29, 1'b1, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL stable_abort tick=%0d got=%b exp=%b", n, obs, exp);
      end
      if (n == 9) bus.locked = 1'b1;
      if (n == 14) bus.locked = 1'b0;
    end
    total++;
    if (bus.relock_count !== 2'd0) begin
      bad++;
      $display("FAIL stable_abort_relock got=%0d exp=0", bus.relock_count);
    end
  endtask

  task automatic test_timeout_fail();
    logic [4:0] exp;
    do_reset();
    for (int n = 1; n <= 148; n++) begin
      tick();
      exp = {n < 4 || (n >= 24 && n < 28), 1'b1, 1'b0, n >= 48, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL timeout_fail tick=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [4:0] exp;
    logic       run;
    do_reset();
    for (int n = 1; n <= 50; n++) begin
      tick();
      run = (n >= 20 && n < 28) || n >= 43;
      exp = {n < 4 || (n >= 28 && n < 32), !run, run, 1'b0, n == 28};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL lock_loss tick=%0d got=%b exp=%b", n, obs, exp);
      end
      total++;
      if (bus.relock_count !== ((n >= 28) ? 2'd1 : 2'd0)) begin
        bad++;
        $display("FAIL lock_loss_relock tick=%0d got=%0d exp=%0d", n, bus.relock_count, (n >= 28) ? 1 : 0);
      end
      if (n == 9) bus.locked = 1'b1;
      if (n == 25) bus.locked = 1'b0;
      if (n == 32) bus.locked = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 9) bus.locked = 1'b1;
    end
    total++;
    if (bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_initial_ready got=%b exp=1", bus.ready);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      bus.locked = 1'b0;
      tick();
      tick();
      total++;
      if ({bus.ready, bus.lock_loss} !== 2'b10) begin
        bad++;
        $display("FAIL b2b_pre_drop k=%0d got=%b exp=10", k, {bus.ready, bus.lock_loss});
      end
      tick();
      total++;
      if ({bus.ready, bus.lock_loss, bus.pll_rst} !== 3'b011) begin
        bad++;
        $display("FAIL b2b_drop k=%0d got=%b exp=011", k, {bus.ready, bus.lock_loss, bus.pll_rst});
      end
      total++;
      if (bus.relock_count !== exp_cnt) begin
        bad++;
        $display("FAIL b2b_relock k=%0d got=%0d exp=%0d", k, bus.relock_count, exp_cnt);
      end
      bus.locked = 1'b1;
      for (int n = 1; n <= 12; n++) tick();
      total++;
      if (bus.ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_early_ready k=%0d got=%b exp=0", k, bus.ready);
      end
      tick();
      total++;
      if (bus.ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready k=%0d got=%b exp=1", k, bus.ready);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 5'b11000) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", obs, 5'b11000);
    end
    total++;
    if (bus.relock_count !== 2'd0) begin
      bad++;
      $display("FAIL async_reset_relock got=%0d exp=0", bus.relock_count);
    end
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      exp = {n < 4, n < 13, n >= 13, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL async_rerun tick=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  initial begin
    bus.locked = 1'b0;
    test_reset();
    test_lock_sequence();
    test_stable_abort();
    test_timeout_fail();
    test_lock_loss();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
